// File: rtl/sparc_icc_pkg.sv
// sparc_icc_pkg: shared Bicc condition codes, icc bit positions and branch FSM states.
// Rev 1.0
`default_nettype none

package sparc_icc_pkg;

  localparam logic [3:0] COND_BN   = 4'b0000;
  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BLE  = 4'b0010;
  localparam logic [3:0] COND_BL   = 4'b0011;
  localparam logic [3:0] COND_BLEU = 4'b0100;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;
  localparam logic [3:0] COND_BNE  = 4'b1001;
  localparam logic [3:0] COND_BG   = 4'b1010;
  localparam logic [3:0] COND_BGE  = 4'b1011;
  localparam logic [3:0] COND_BGU  = 4'b1100;
  localparam logic [3:0] COND_BCC  = 4'b1101;
  localparam logic [3:0] COND_BPOS = 4'b1110;
  localparam logic [3:0] COND_BVC  = 4'b1111;

  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOT  = 2'd1,
    ST_ANNUL = 2'd2
  } br_state_t;

endpackage

`default_nettype wire

// File: rtl/icc_cond_eval.sv
// icc_cond_eval: combinational Bicc/Ticc condition resolver, (cond, icc) -> taken.
// Rev 1.0
`default_nettype none

module icc_cond_eval
  import sparc_icc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] icc,
  output logic       taken
);

  logic n, z, v, c;
  logic base;

  assign n = icc[ICC_N];
  assign z = icc[ICC_Z];
  assign v = icc[ICC_V];
  assign c = icc[ICC_C];

  // The upper eight encodings are the complements of the lower eight.
  always_comb begin
    base = 1'b0;
    case (cond[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = c | z;
      3'd5: base = c;
      3'd6: base = n;
      3'd7: base = v;
      default: base = 1'b0;
    endcase
    taken = base ^ cond[3];
  end

endmodule

`default_nettype wire

// File: rtl/icc_branch_resolver.sv
// icc_branch_resolver: icc register plus Bicc resolve and delay-slot/annul sequencing.
// Rev 1.0 -- ICC_BYPASS_EN forwards same-edge ALU flags into the condition evaluation.
`default_nettype none

module icc_branch_resolver
  import sparc_icc_pkg::*;
#(
  parameter logic [3:0] ICC_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_we,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_c,
  input  logic       stall,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  input  logic       br_annul,
  output logic [3:0] icc,
  output logic       br_taken,
  output logic       annul_slot,
  output logic       dcti_err
);

  br_state_t  state;
  logic [3:0] alu_flags;
  logic [3:0] eval_icc;
  logic       cond_true;

  assign alu_flags = {alu_n, alu_z, alu_v, alu_c};

`ifdef ICC_BYPASS_EN
  assign eval_icc = flag_we ? alu_flags : icc;
`else
  assign eval_icc = icc;
`endif

  icc_cond_eval u_cond_eval (
    .cond  (br_cond),
    .icc   (eval_icc),
    .taken (cond_true)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      icc        <= ICC_RESET;
      br_taken   <= 1'b0;
      annul_slot <= 1'b0;
      dcti_err   <= 1'b0;
    end else begin
      if (flag_we)
        icc <= alu_flags;
      br_taken <= 1'b0;
      dcti_err <= 1'b0;
      if (!stall) begin
        case (state)
          ST_IDLE: begin
            if (br_valid) begin
              br_taken <= cond_true;
              // BA,a squashes its slot even though it is taken.
              if (br_annul && (!cond_true || br_cond == COND_BA)) begin
                state      <= ST_ANNUL;
                annul_slot <= 1'b1;
              end else begin
                state <= ST_SLOT;
              end
            end
          end
          ST_SLOT: begin
            state      <= ST_IDLE;
            annul_slot <= 1'b0;
            if (br_valid)
              dcti_err <= 1'b1;
          end
          ST_ANNUL: begin
            state      <= ST_IDLE;
            annul_slot <= 1'b0;
          end
          default: begin
            state      <= ST_IDLE;
            annul_slot <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icc_branch_resolver.sv
// tb_icc_branch_resolver: directed self-checking bench for icc_branch_resolver.
// Rev 1.0
`default_nettype none

module tb_icc_branch_resolver;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_we;
  logic       alu_n, alu_z, alu_v, alu_c;
  logic       stall;
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_annul;
  logic [3:0] icc;
  logic       br_taken;
  logic       annul_slot;
  logic       dcti_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  icc_branch_resolver #(.ICC_RESET(4'b0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .flag_we    (flag_we),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_v      (alu_v),
    .alu_c      (alu_c),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_cond    (br_cond),
    .br_annul   (br_annul),
    .icc        (icc),
    .br_taken   (br_taken),
    .annul_slot (annul_slot),
    .dcti_err   (dcti_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand-written condition table, indexed by cond, flags ordered {N,Z,V,C}.
  function automatic logic model(input logic [3:0] cnd, input logic [3:0] f);
    logic n, z, v, c;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cnd)
      4'd0:  return 1'b0;
      4'd1:  return z;
      4'd2:  return z | (n ^ v);
      4'd3:  return n ^ v;
      4'd4:  return c | z;
      4'd5:  return c;
      4'd6:  return n;
      4'd7:  return v;
      4'd8:  return 1'b1;
      4'd9:  return !z;
      4'd10: return !(z | (n ^ v));
      4'd11: return !(n ^ v);
      4'd12: return !(c | z);
      4'd13: return !c;
      4'd14: return !n;
      default: return !v;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_we = 1'b1;
    {alu_n, alu_z, alu_v, alu_c} = f;
    tick();
    flag_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] cnd, input logic a);
    br_valid = 1'b1;
    br_cond  = cnd;
    br_annul = a;
    tick();
    br_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flag_we = 1'b0; stall = 1'b0; br_valid = 1'b0;
    br_cond = 4'd0; br_annul = 1'b0;
    {alu_n, alu_z, alu_v, alu_c} = 4'b0000;
    #12;
    check("rst_icc", icc, 4'b0000);
    check("rst_taken", br_taken, 0);
    check("rst_annul", annul_slot, 0);
    check("rst_dcti", dcti_err, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Full sweep: every flag pattern against every cond with a=0.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        set_flags(f[3:0]);
        issue(c[3:0], 1'b0);
        check($sformatf("sweep_f%0d_c%0d", f, c), br_taken, model(c[3:0], f[3:0]));
        if (c == 0) begin
          check($sformatf("sweep_icc_f%0d", f), icc, f[3:0]);
          check($sformatf("sweep_noannul_f%0d", f), annul_slot, 0);
        end
      end
      tick();
    end

    // Z set: BNE,a is untaken and annuls; BE,a is taken and keeps the slot.
    set_flags(4'b0100);
    check("z_icc", icc, 4'b0100);
    issue(4'b1001, 1'b1);
    check("bne_a_taken", br_taken, 0);
    check("bne_a_annul", annul_slot, 1);
    tick();
    check("bne_a_annul_drop", annul_slot, 0);
    issue(4'b0001, 1'b1);
    check("be_a_taken", br_taken, 1);
    check("be_a_annul", annul_slot, 0);
    tick();

    // BA,a annuls; slot held through three stalled cycles.
    issue(4'b1000, 1'b1);
    check("ba_a_taken", br_taken, 1);
    check("ba_a_annul", annul_slot, 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ba_a_stall%0d_annul", i), annul_slot, 1);
      check($sformatf("ba_a_stall%0d_taken", i), br_taken, 0);
    end
    stall = 1'b0;
    tick();
    check("ba_a_release", annul_slot, 0);

    // Flags keep loading under stall.
    stall = 1'b1;
    set_flags(4'b1010);
    check("stall_icc_load", icc, 4'b1010);
    stall = 1'b0;

    // Same-edge flag write and BE: forwarded only in the bypass build.
    set_flags(4'b0000);
    flag_we = 1'b1;
    {alu_n, alu_z, alu_v, alu_c} = 4'b0100;
    issue(4'b0001, 1'b0);
    flag_we = 1'b0;
`ifdef ICC_BYPASS_EN
    check("bypass_be", br_taken, 1);
`else
    check("bypass_be", br_taken, 0);
`endif
    check("bypass_icc", icc, 4'b0100);
    tick();

    // Branch in an executing slot raises dcti_err once.
    issue(4'b1000, 1'b0);
    check("dcti_first_taken", br_taken, 1);
    issue(4'b1000, 1'b0);
    check("dcti_pulse", dcti_err, 1);
    check("dcti_no_taken", br_taken, 0);
    tick();
    check("dcti_pulse_end", dcti_err, 0);
    check("dcti_idle_taken", br_taken, 0);

    // Branch in an annulled slot is ignored.
    issue(4'b0000, 1'b1);
    check("bn_a_annul", annul_slot, 1);
    check("bn_a_taken", br_taken, 0);
    issue(4'b1000, 1'b0);
    check("annul_no_dcti", dcti_err, 0);
    check("annul_no_taken", br_taken, 0);
    check("annul_done", annul_slot, 0);
    tick();

    // Async reset mid-ANNUL drops annul_slot without a clock edge.
    issue(4'b0000, 1'b1);
    check("pre_rst_annul", annul_slot, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_annul", annul_slot, 0);
    check("async_rst_icc", icc, 4'b0000);
    #1 rst = 1'b0;
    tick();
    check("post_rst_annul", annul_slot, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
